// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and constants for the two-port SRAM arbiter.
package sram_arb_pkg;

    // Default geometry of the attached SRAM and its read timing.
    localparam int DEF_AW     = 10;
    localparam int DEF_DW     = 32;
    localparam int DEF_RD_LAT = 2;

    // Port indices used for request vectors, grant pointer and read ownership.
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;

endpackage

// File: rtl/sram_rr_pick.sv
// sram_rr_pick: two-way request picker, purely combinational.
// Build option: SRAM_ARB_FIXED_PRIO_EN selects fixed A-over-B priority;
// otherwise contention goes to the port that was not granted last.
module sram_rr_pick
    import sram_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       win_o,
    output logic       valid_o
);

    assign valid_o = |req_i;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    // The grant history is irrelevant when A always wins.
    logic unused_last;
    assign unused_last = last_i;

    // A wins whenever it asks; B only when A is quiet.
    always_comb begin
        win_o = req_i[PORT_A] ? PORT_A : PORT_B;
    end
`else
    // On contention hand the access to the port that did not get the last one.
    always_comb begin
        if (req_i[PORT_A] && req_i[PORT_B]) begin
            win_o = ~last_i;
        end else if (req_i[PORT_A]) begin
            win_o = PORT_A;
        end else begin
            win_o = PORT_B;
        end
    end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: grants ports A/B one at a time onto a single-port SRAM,
// sequences the active-low rd_/wr_ strobes, owns the shared data bus during
// writes and returns read data with a one-cycle valid pulse.
// Build option: SRAM_ARB_FIXED_PRIO_EN (fixed priority, see sram_rr_pick).
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int AW     = DEF_AW,
    parameter int DW     = DEF_DW,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdat,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdat,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdat,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdat,
    output logic [AW-1:0] sram_addr,
    output logic          sram_rd_,
    output logic          sram_wr_,
    inout  wire  [DW-1:0] sram_dat,
    output logic          busy
);

    localparam int            CW       = $clog2(RD_LAT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(RD_LAT);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          rd_n_q, rd_n_d;
    logic          wr_n_q, wr_n_d;
    logic          oe_q, oe_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
    logic          a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
    logic [DW-1:0] a_rdat_q, a_rdat_d, b_rdat_q, b_rdat_d;
    logic          busy_q, busy_d;

    logic          win, win_valid, arb;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdat;

    sram_rr_pick u_pick (
        .req_i   ({b_req, a_req}),
        .last_i  (last_q),
        .win_o   (win),
        .valid_o (win_valid)
    );

    // Route the winning port's request fields to the sequencer.
    always_comb begin
        if (win == PORT_B) begin
            sel_we   = b_we;
            sel_addr = b_addr;
            sel_wdat = b_wdat;
        end else begin
            sel_we   = a_we;
            sel_addr = a_addr;
            sel_wdat = a_wdat;
        end
    end

    // Next state, SRAM command and per-port responses; arbitrate at every access boundary.
    always_comb begin
        // NOTE: every _d starts from its hold/idle value so no branch can leave a latch behind.
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        last_d     = last_q;
        addr_d     = addr_q;
        rd_n_d     = 1'b1;
        wr_n_d     = 1'b1;
        oe_d       = 1'b0;
        dout_d     = dout_q;
        a_gnt_d    = 1'b0;
        b_gnt_d    = 1'b0;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        a_rdat_d   = a_rdat_q;
        b_rdat_d   = b_rdat_q;
        arb        = 1'b0;

        case (state_q)
            IDLE:  arb = 1'b1;
            WRITE: arb = 1'b1;
            READ: begin
                if (cnt_q == CNT_LAST) begin
                    // Last read cycle: the SRAM has had RD_LAT cycles to settle dat.
                    arb = 1'b1;
                    if (owner_q == PORT_A) begin
                        a_rdat_d   = sram_dat;
                        a_rvalid_d = 1'b1;
                    end else begin
                        b_rdat_d   = sram_dat;
                        b_rvalid_d = 1'b1;
                    end
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                    rd_n_d = 1'b0;
                end
            end
            default: arb = 1'b1;
        endcase

        // Back-to-back accesses: the completion edge doubles as the next grant edge.
        if (arb) begin
            state_d = IDLE;
            if (win_valid) begin
                owner_d = win;
                last_d  = win;
                addr_d  = sel_addr;
                if (win == PORT_A) begin
                    a_gnt_d = 1'b1;
                end else begin
                    b_gnt_d = 1'b1;
                end
                if (sel_we) begin
                    state_d = WRITE;
                    wr_n_d  = 1'b0;
                    oe_d    = 1'b1;
                    dout_d  = sel_wdat;
                end else begin
                    state_d = READ;
                    rd_n_d  = 1'b0;
                    cnt_d   = CW'(1);
                end
            end
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset releases the SRAM bus at once.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            owner_q    <= PORT_A;
            last_q     <= PORT_B;
            addr_q     <= '0;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            oe_q       <= 1'b0;
            dout_q     <= '0;
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdat_q   <= '0;
            b_rdat_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register updates from pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            oe_q       <= oe_d;
            dout_q     <= dout_d;
            a_gnt_q    <= a_gnt_d;
            b_gnt_q    <= b_gnt_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdat_q   <= a_rdat_d;
            b_rdat_q   <= b_rdat_d;
            busy_q     <= busy_d;
        end
    end

    assign sram_dat  = oe_q ? dout_q : {DW{1'bz}};
    assign sram_addr = addr_q;
    assign sram_rd_  = rd_n_q;
    assign sram_wr_  = wr_n_q;
    assign a_gnt     = a_gnt_q;
    assign b_gnt     = b_gnt_q;
    assign a_rvalid  = a_rvalid_q;
    assign b_rvalid  = b_rvalid_q;
    assign a_rdat    = a_rdat_q;
    assign b_rdat    = b_rdat_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed scenarios plus randomized traffic on both ports,
// checked every cycle against a transaction-level model of the arbiter.
`timescale 1ns/1ps
module tb_sram_arbiter;

    localparam int AW     = 10;
    localparam int DW     = 32;
    localparam int RD_LAT = 2;

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdat;
    } req_t;

    logic          clk = 1'b0;
    logic          rst_;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdat, b_wdat;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DW-1:0] a_rdat, b_rdat;
    logic [AW-1:0] sram_addr;
    logic          sram_rd_, sram_wr_, busy;
    wire  [DW-1:0] sram_dat;

    sram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .rst_      (rst_),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdat    (a_wdat),
        .a_gnt     (a_gnt),
        .a_rvalid  (a_rvalid),
        .a_rdat    (a_rdat),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdat    (b_wdat),
        .b_gnt     (b_gnt),
        .b_rvalid  (b_rvalid),
        .b_rdat    (b_rdat),
        .sram_addr (sram_addr),
        .sram_rd_  (sram_rd_),
        .sram_wr_  (sram_wr_),
        .sram_dat  (sram_dat),
        .busy      (busy)
    );

    always #20 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic req_t mk(input bit we, input int addr, input logic [DW-1:0] wdat);
        mk.we   = we;
        mk.addr = AW'(addr);
        mk.wdat = wdat;
    endfunction

    // ---------------- behavioural SRAM (drives dat while rd_ low, writes on negedge)
    logic [DW-1:0] sram_mem [0:1023];
    assign sram_dat = (sram_rd_ == 1'b0) ? sram_mem[sram_addr] : {DW{1'bz}};

    initial begin
        for (int i = 0; i < 1024; i++) sram_mem[i] = '0;
        sram_mem[1] = 32'h11;
        sram_mem[2] = 32'h22;
        forever begin
            @(negedge clk);
            if (sram_wr_ == 1'b0) sram_mem[sram_addr] = sram_dat;
        end
    end

    // ---------------- requesters: each port works through its own queue
    req_t qa[$];
    req_t qb[$];

    initial begin
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdat = '0;
        forever begin
            @(posedge clk); #1;
            if (a_req && a_gnt) qa.delete(0);
            if (rst_ !== 1'b1 || qa.size() == 0) a_req = 1'b0;
            else begin
                a_req = 1'b1; a_we = qa[0].we; a_addr = qa[0].addr; a_wdat = qa[0].wdat;
            end
        end
    end

    initial begin
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdat = '0;
        forever begin
            @(posedge clk); #1;
            if (b_req && b_gnt) qb.delete(0);
            if (rst_ !== 1'b1 || qb.size() == 0) b_req = 1'b0;
            else begin
                b_req = 1'b1; b_we = qb[0].we; b_addr = qb[0].addr; b_wdat = qb[0].wdat;
            end
        end
    end

    // ---------------- transaction-level model
    // An access granted at edge k occupies the SRAM until edge k+1 (write) or
    // k+RD_LAT (read); the next grant happens on that edge.
    logic [DW-1:0] mdl_mem [0:1023];
    bit            m_busy, m_we, m_port, m_last, m_ra, m_rb, m_w, model_armed;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdat, m_rexp;
    int            m_k, m_start, m_free_at;
    bit            e_a_gnt, e_b_gnt, e_a_rv, e_b_rv;
    logic [DW-1:0] e_a_rdat, e_b_rdat;
    logic [AW-1:0] e_addr;

    initial begin
        model_armed = 1'b0;
        for (int i = 0; i < 1024; i++) mdl_mem[i] = '0;
        mdl_mem[1] = 32'h11;
        mdl_mem[2] = 32'h22;
        forever begin
            @(posedge clk);
            if (rst_ !== 1'b1) begin
                m_busy = 0; m_k = 0; m_free_at = 0; m_last = 1'b1;
                e_a_gnt = 0; e_b_gnt = 0; e_a_rv = 0; e_b_rv = 0;
                e_a_rdat = '0; e_b_rdat = '0; e_addr = '0;
                model_armed = 1'b1;
            end else begin
                m_k++;
                e_a_gnt = 0; e_b_gnt = 0; e_a_rv = 0; e_b_rv = 0;
                if (m_busy && !m_we && m_k == m_start + RD_LAT) begin
                    if (m_port) begin e_b_rdat = m_rexp; e_b_rv = 1; end
                    else        begin e_a_rdat = m_rexp; e_a_rv = 1; end
                end
                if (m_k >= m_free_at) begin
                    m_busy = 0;
                    m_ra = a_req;
                    m_rb = b_req;
                    if (m_ra || m_rb) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
                        m_w = (m_ra && m_rb) ? 1'b0 : m_rb;
`else
                        m_w = (m_ra && m_rb) ? !m_last : m_rb;
`endif
                        m_we   = m_w ? b_we   : a_we;
                        m_addr = m_w ? b_addr : a_addr;
                        m_wdat = m_w ? b_wdat : a_wdat;
                        m_busy = 1; m_port = m_w; m_last = m_w; m_start = m_k;
                        e_addr = m_addr;
                        if (m_w) e_b_gnt = 1; else e_a_gnt = 1;
                        if (m_we) begin
                            mdl_mem[m_addr] = m_wdat;
                            m_free_at = m_k + 1;
                        end else begin
                            m_rexp = mdl_mem[m_addr];
                            m_free_at = m_k + RD_LAT;
                        end
                    end else begin
                        m_free_at = m_k + 1;
                    end
                end
            end
        end
    end

    // ---------------- compare process: every mid-cycle while out of reset
    initial begin
        forever begin
            @(negedge clk);
            if (rst_ === 1'b1 && model_armed) begin
                check("a_gnt",     a_gnt,     e_a_gnt);
                check("b_gnt",     b_gnt,     e_b_gnt);
                check("a_rvalid",  a_rvalid,  e_a_rv);
                check("b_rvalid",  b_rvalid,  e_b_rv);
                check("a_rdat",    a_rdat,    e_a_rdat);
                check("b_rdat",    b_rdat,    e_b_rdat);
                check("sram_addr", sram_addr, e_addr);
                check("sram_rd_",  sram_rd_,  !(m_busy && !m_we));
                check("sram_wr_",  sram_wr_,  !(m_busy && m_we));
                check("busy",      busy,      m_busy);
                check("rd_wr_excl", (sram_rd_ == 1'b0 && sram_wr_ == 1'b0), 1'b0);
                if (m_busy && m_we)  check("wr_bus_dat", sram_dat, m_wdat);
                if (m_busy && !m_we) check("rd_bus_dat", sram_dat, mdl_mem[m_addr]);
            end
        end
    end

    // ---------------- event log for the directed scenarios
    int            ncyc = 0;
    int            gnt_port[$], gnt_cyc[$], rv_port[$], rv_cyc[$], wr_cyc[$], rd_cyc[$];
    logic [DW-1:0] rv_data[$];

    initial begin
        forever begin
            @(negedge clk);
            ncyc++;
            if (rst_ === 1'b1) begin
                if (a_gnt)    begin gnt_port.push_back(0); gnt_cyc.push_back(ncyc); end
                if (b_gnt)    begin gnt_port.push_back(1); gnt_cyc.push_back(ncyc); end
                if (a_rvalid) begin rv_port.push_back(0); rv_cyc.push_back(ncyc); rv_data.push_back(a_rdat); end
                if (b_rvalid) begin rv_port.push_back(1); rv_cyc.push_back(ncyc); rv_data.push_back(b_rdat); end
                if (sram_wr_ == 1'b0) wr_cyc.push_back(ncyc);
                if (sram_rd_ == 1'b0) rd_cyc.push_back(ncyc);
            end
        end
    end

    task automatic clear_logs();
        gnt_port.delete(); gnt_cyc.delete(); rv_port.delete(); rv_cyc.delete();
        rv_data.delete(); wr_cyc.delete(); rd_cyc.delete();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0 || a_req || b_req || busy) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_budget", n < 2000, 1'b1);
        repeat (RD_LAT + 2) @(posedge clk);
        #3;
    endtask

    // ---------------- sequencer
    int   exp2 [8];
    int   n;
    req_t r;

    initial begin
        rst_ = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_",    sram_rd_,  1'b1);
        check("rst_wr_",    sram_wr_,  1'b1);
        check("rst_busy",   busy,      1'b0);
        check("rst_addr",   sram_addr, 10'h000);
        check("rst_a_gnt",  a_gnt,     1'b0);
        check("rst_b_rv",   b_rvalid,  1'b0);
        check("rst_a_rdat", a_rdat,    32'h0);
        @(negedge clk); #2;
        rst_ = 1'b1;

        // Both ports read together, four times each.
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            qa.push_back(mk(0, 'h001, '0));
            qb.push_back(mk(0, 'h002, '0));
        end
        drain();
`ifdef SRAM_ARB_FIXED_PRIO_EN
        exp2 = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
        exp2 = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
        check("s2_gnt_count", gnt_port.size(), 8);
        check("s2_rv_count",  rv_port.size(),  8);
        if (gnt_port.size() == 8)
            for (int i = 0; i < 8; i++) check("s2_gnt_order", gnt_port[i], exp2[i]);
        for (int i = 0; i < rv_port.size(); i++)
            check("s2_rv_data", rv_data[i], (rv_port[i] == 0) ? 32'h11 : 32'h22);

        // A writes 0x3FF then reads it back.
        clear_logs();
        qa.push_back(mk(1, 'h3FF, 32'hDEADBEEF));
        qa.push_back(mk(0, 'h3FF, '0));
        drain();
        check("s1_gnt_count",  gnt_port.size(), 2);
        check("s1_wr_cycles",  wr_cyc.size(),   1);
        check("s1_rv_count",   rv_port.size(),  1);
        if (gnt_cyc.size() == 2 && rv_cyc.size() == 1)
            check("s1_rd_latency", rv_cyc[0] - gnt_cyc[1], 2);
        check("s1_a_rdat", a_rdat, 32'hDEADBEEF);

        // B write followed immediately by an A read of the same word.
        clear_logs();
        qb.push_back(mk(1, 'h010, 32'h12345678));
        @(posedge clk); #3;
        qa.push_back(mk(0, 'h010, '0));
        drain();
        check("s3_wr_cycles", wr_cyc.size(), 1);
        if (wr_cyc.size() == 1 && rd_cyc.size() > 0)
            check("s3_no_bubble", rd_cyc[0], wr_cyc[0] + 1);
        check("s3_a_rdat", a_rdat, 32'h12345678);

        // Reset in the first cycle of an A read.
        clear_logs();
        qa.push_back(mk(0, 'h3FF, '0));
        n = 0;
        while (!a_gnt && n < 50) begin
            @(posedge clk); #3;
            n++;
        end
        check("s4_gnt_seen", a_gnt, 1'b1);
        rst_ = 1'b0;
        #1;
        check("s4_rd_",    sram_rd_,  1'b1);
        check("s4_wr_",    sram_wr_,  1'b1);
        check("s4_busy",   busy,      1'b0);
        check("s4_addr",   sram_addr, 10'h000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("s4_no_rv",  a_rvalid,  1'b0);
        #2;
        rst_ = 1'b1;
        qa.push_back(mk(0, 'h3FF, '0));
        drain();
        check("s4_rv_count", rv_port.size(), 1);
        if (rv_data.size() > 0) check("s4_rv_data", rv_data[0], 32'hDEADBEEF);
        check("s4_a_rdat", a_rdat, 32'hDEADBEEF);

        // Both ports keep requesting writes.
        clear_logs();
        for (int i = 0; i < 6; i++) begin
            qa.push_back(mk(1, 'h020 + i, $urandom()));
            qb.push_back(mk(1, 'h030 + i, $urandom()));
        end
        drain();
        check("s5_gnt_count", gnt_port.size(), 12);
        if (gnt_port.size() == 12) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            for (int i = 0; i < 6; i++) check("s5_only_a", gnt_port[i], 0);
`else
            for (int i = 0; i < 11; i++) check("s5_alternate", gnt_port[i] != gnt_port[i+1], 1'b1);
`endif
        end

        // Random mixed traffic over a small address window.
        clear_logs();
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #3;
            if (qa.size() < 3 && $urandom_range(0, 2) == 0) begin
                r = mk($urandom_range(0, 1) == 1, 'h100 + $urandom_range(0, 7), $urandom());
                qa.push_back(r);
            end
            if (qb.size() < 3 && $urandom_range(0, 2) == 0) begin
                r = mk($urandom_range(0, 1) == 1, 'h100 + $urandom_range(0, 7), $urandom());
                qb.push_back(r);
            end
        end
        drain();
        check("rand_reads_seen", rv_port.size() > 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
